// File: rtl/wb_pkg.sv
// Shared constants for the uv-risc writeback scheduler: requester indices,
// special register numbers, datapath widths and the round-robin step helper.
package wb_pkg;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int RW   = 3;
  localparam int FW   = 4;
  localparam int NREG = 1 << RW;

  localparam logic [1:0] REQ_ALU  = 2'd0;
  localparam logic [1:0] REQ_LOAD = 2'd1;
  localparam logic [1:0] REQ_MUL  = 2'd2;

  localparam logic [RW-1:0] R0  = 3'd0;
  localparam logic [RW-1:0] RHI = 3'd1;

  // Requester index 'off' positions after 'p', wrapping modulo NREQ.
  function automatic logic [1:0] rr_next(input logic [1:0] p, input int off);
    int s;
    s = (int'(p) + off) % NREQ;
    return 2'(s);
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter. The search starts just after the last
// winner held in 'ptr'; the pointer register itself lives in the caller.
module rr_arb3
  import wb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic [1:0] idx,
  output logic       any
);

  // First valid requester after the pointer wins; grant is one-hot or zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant = '0;
    idx   = REQ_ALU;
    any   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && valid[rr_next(ptr, k)]) begin
        idx = rr_next(ptr, k);
        any = 1'b1;
      end
    end
    if (any) grant = 3'b001 << idx;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback scheduler: shares the regfile write, hi and flags ports among the
// ALU, LOAD and MUL result producers and tracks pending writes per register.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*RW-1:0]   req_dest,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_flags_upd,
  input  logic [NREQ*FW-1:0]   req_flags,
  input  logic [DW-1:0]        mul_hi,
  input  logic                 alloc_we,
  input  logic [RW-1:0]        alloc_sel,
  output logic [NREG-1:0]      busy,
  output logic                 reg_we,
  output logic [RW-1:0]        wr_sel,
  output logic [DW-1:0]        data_in,
  output logic                 hi_we,
  output logic [DW-1:0]        hi_in,
  output logic                 flags_we,
  output logic [FW-1:0]        flags_in
);

  logic [1:0]      rr_ptr;
  logic [2:0]      grant;
  logic [1:0]      gnt_idx;
  logic            gnt_any;
  logic            xfer;
  logic            is_mul;
  logic [RW-1:0]   sel_dest;
  logic [DW-1:0]   sel_data;
  logic            sel_upd;
  logic [FW-1:0]   sel_flags;
  logic [NREG-1:0] busy_next;

  rr_arb3 u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Grant is computed from valid only; ready is masked while reset is held.
  assign req_ready = reset ? grant : '0;
  assign xfer      = gnt_any && reset;
  assign is_mul    = (gnt_idx == REQ_MUL);

  // Route the winning requester's payload to the write path.
  always_comb begin
    sel_dest  = req_dest[0*RW +: RW];
    sel_data  = req_data[0*DW +: DW];
    sel_upd   = req_flags_upd[0];
    sel_flags = req_flags[0*FW +: FW];
    case (gnt_idx)
      REQ_LOAD: begin
        sel_dest  = req_dest[1*RW +: RW];
        sel_data  = req_data[1*DW +: DW];
        sel_upd   = req_flags_upd[1];
        sel_flags = req_flags[1*FW +: FW];
      end
      REQ_MUL: begin
        sel_dest  = req_dest[2*RW +: RW];
        sel_data  = req_data[2*DW +: DW];
        sel_upd   = req_flags_upd[2];
        sel_flags = req_flags[2*FW +: FW];
      end
      default: ;
    endcase
  end

  // Scoreboard next state: clear on writeback, set on issue; set wins, R0 never pends.
  always_comb begin
    busy_next = busy;
    if (xfer) begin
      busy_next[sel_dest] = 1'b0;
      if (is_mul) busy_next[RHI] = 1'b0;
    end
    if (alloc_we) busy_next[alloc_sel] = 1'b1;
    busy_next[R0] = 1'b0;
  end

  // Register the regfile write ports, scoreboard and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      reg_we   <= 1'b0;
      hi_we    <= 1'b0;
      flags_we <= 1'b0;
      wr_sel   <= '0;
      data_in  <= '0;
      hi_in    <= '0;
      flags_in <= '0;
      busy     <= '0;
      rr_ptr   <= REQ_MUL;
    end else begin
      busy     <= busy_next;
      reg_we   <= 1'b0;
      hi_we    <= 1'b0;
      flags_we <= 1'b0;
      if (xfer) begin
        rr_ptr   <= gnt_idx;
        wr_sel   <= sel_dest;
        data_in  <= sel_data;
        hi_in    <= mul_hi;
        flags_in <= sel_flags;
        reg_we   <= (sel_dest != R0) && !(is_mul && sel_dest == RHI);
        hi_we    <= is_mul;
        flags_we <= sel_upd;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed grants, write-port values and
// scoreboard contents, checked with immediate assertions.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [8:0]  req_dest;
  logic [47:0] req_data;
  logic [2:0]  req_flags_upd;
  logic [11:0] req_flags;
  logic [15:0] mul_hi;
  logic        alloc_we;
  logic [2:0]  alloc_sel;
  logic [7:0]  busy;
  logic        reg_we;
  logic [2:0]  wr_sel;
  logic [15:0] data_in;
  logic        hi_we;
  logic [15:0] hi_in;
  logic        flags_we;
  logic [3:0]  flags_in;

  int errors = 0;
  int checks = 0;

  wb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dest      (req_dest),
    .req_data      (req_data),
    .req_flags_upd (req_flags_upd),
    .req_flags     (req_flags),
    .mul_hi        (mul_hi),
    .alloc_we      (alloc_we),
    .alloc_sel     (alloc_sel),
    .busy          (busy),
    .reg_we        (reg_we),
    .wr_sel        (wr_sel),
    .data_in       (data_in),
    .hi_we         (hi_we),
    .hi_in         (hi_in),
    .flags_we      (flags_we),
    .flags_in      (flags_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] dest, input logic [15:0] data,
                         input logic upd, input logic [3:0] fl);
    req_valid[i]       = 1'b1;
    req_dest[i*3 +: 3] = dest;
    req_data[i*16 +: 16] = data;
    req_flags_upd[i]   = upd;
    req_flags[i*4 +: 4] = fl;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid     = '0;
    req_flags_upd = '0;
    alloc_we      = 1'b0;
    alloc_sel     = '0;
  endtask

  logic [2:0] rr_exp [6];
  logic [2:0] rr_dst [6];

  initial begin
    reset    = 1'b0;
    req_dest = '0;
    req_data = '0;
    req_flags = '0;
    mul_hi   = '0;
    idle_inputs();

    // Reset state; ready must stay low while reset is held even if valid.
    tick();
    req_valid[0] = 1'b1;
    #1;
    check("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    check("rst_reg_we", 32'(reg_we), 0);
    check("rst_hi_we", 32'(hi_we), 0);
    check("rst_flags_we", 32'(flags_we), 0);
    check("rst_wr_sel", 32'(wr_sel), 0);
    check("rst_data_in", 32'(data_in), 0);
    check("rst_hi_in", 32'(hi_in), 0);
    check("rst_flags_in", 32'(flags_in), 0);
    check("rst_busy", 32'(busy), 0);
    idle_inputs();
    reset = 1'b1;

    // Single ALU write.
    set_req(0, 3'd3, 16'h1234, 1'b1, 4'hA);
    #1;
    check("alu_ready", 32'(req_ready), 32'b001);
    tick();
    idle_inputs();
    check("alu_reg_we", 32'(reg_we), 1);
    check("alu_wr_sel", 32'(wr_sel), 3);
    check("alu_data_in", 32'(data_in), 32'h1234);
    check("alu_flags_we", 32'(flags_we), 1);
    check("alu_flags_in", 32'(flags_in), 32'hA);
    check("alu_hi_we", 32'(hi_we), 0);

    // Idle cycle: enables drop, data holds.
    tick();
    check("idle_reg_we", 32'(reg_we), 0);
    check("idle_flags_we", 32'(flags_we), 0);
    check("idle_data_hold", 32'(data_in), 32'h1234);

    // MUL to R1: hi half owns R1, lo write suppressed.
    set_req(2, 3'd1, 16'h0001, 1'b0, 4'h0);
    mul_hi = 16'hBEEF;
    #1;
    check("mul1_ready", 32'(req_ready), 32'b100);
    tick();
    idle_inputs();
    check("mul1_reg_we", 32'(reg_we), 0);
    check("mul1_hi_we", 32'(hi_we), 1);
    check("mul1_hi_in", 32'(hi_in), 32'hBEEF);
    check("mul1_flags_we", 32'(flags_we), 0);

    // MUL to R5: both halves written.
    set_req(2, 3'd5, 16'h0001, 1'b0, 4'h0);
    #1;
    check("mul5_ready", 32'(req_ready), 32'b100);
    tick();
    idle_inputs();
    check("mul5_reg_we", 32'(reg_we), 1);
    check("mul5_wr_sel", 32'(wr_sel), 5);
    check("mul5_data_in", 32'(data_in), 32'h0001);
    check("mul5_hi_we", 32'(hi_we), 1);

    // Round-robin with all three valid; last winner was MUL so ALU leads.
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_dst = '{3'd2, 3'd3, 3'd5, 3'd2, 3'd3, 3'd5};
    set_req(0, 3'd2, 16'h00A0, 1'b0, 4'h0);
    set_req(1, 3'd3, 16'h00B0, 1'b0, 4'h0);
    set_req(2, 3'd5, 16'h00C0, 1'b0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(rr_exp[i]));
      tick();
      check($sformatf("rr_wr_sel_%0d", i), 32'(wr_sel), 32'(rr_dst[i]));
    end
    idle_inputs();

    // LOAD to R0: transfer happens, but no regfile write and R0 never pends.
    set_req(1, 3'd0, 16'hFFFF, 1'b0, 4'h0);
    #1;
    check("r0_ready", 32'(req_ready), 32'b010);
    tick();
    idle_inputs();
    check("r0_reg_we", 32'(reg_we), 0);
    check("r0_busy0", 32'(busy[0]), 0);

    // Scoreboard set.
    alloc_we = 1'b1; alloc_sel = 3'd4;
    tick();
    idle_inputs();
    check("sb_alloc4", 32'(busy), 32'h10);

    // Clear and set of the same register in one cycle: set wins.
    set_req(0, 3'd4, 16'h4444, 1'b0, 4'h0);
    alloc_we = 1'b1; alloc_sel = 3'd4;
    #1;
    check("sb_same_ready", 32'(req_ready), 32'b001);
    tick();
    idle_inputs();
    check("sb_set_wins", 32'(busy), 32'h10);
    check("sb_same_wr_sel", 32'(wr_sel), 4);

    // Second writeback to R4 clears it; an alloc of R0 is ignored.
    set_req(0, 3'd4, 16'h4445, 1'b0, 4'h0);
    alloc_we = 1'b1; alloc_sel = 3'd0;
    tick();
    idle_inputs();
    check("sb_clear4", 32'(busy), 32'h00);

    // MUL writeback clears its destination and R1.
    alloc_we = 1'b1; alloc_sel = 3'd1;
    tick();
    alloc_sel = 3'd6;
    tick();
    idle_inputs();
    check("sb_alloc_1_6", 32'(busy), 32'h42);
    set_req(2, 3'd6, 16'h0606, 1'b0, 4'h0);
    tick();
    idle_inputs();
    check("sb_mul_clear", 32'(busy), 32'h00);

    // Reset mid-flight: transfer in the reset cycle is discarded.
    alloc_we = 1'b1; alloc_sel = 3'd3;
    tick();
    idle_inputs();
    check("mid_busy_pre", 32'(busy), 32'h08);
    set_req(1, 3'd2, 16'h2222, 1'b1, 4'h5);
    reset = 1'b0;
    #1;
    check("mid_ready", 32'(req_ready), 32'b000);
    tick();
    check("mid_reg_we", 32'(reg_we), 0);
    check("mid_flags_we", 32'(flags_we), 0);
    check("mid_busy", 32'(busy), 32'h00);
    reset = 1'b1;
    set_req(0, 3'd2, 16'h0AAA, 1'b0, 4'h0);
    set_req(2, 3'd5, 16'h0CCC, 1'b0, 4'h0);
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b001);
    tick();
    idle_inputs();
    check("post_rst_data", 32'(data_in), 32'h0AAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
